axi_burst_master: RTL and testbench

- Parametrised successor to the single-beat AXI controller.
- Accepts one command at a time: a read or write INCR burst of 1..MAX_BURST beats.
- Streams write data in and read data out through valid/ready handshakes, then reports completion and the worst-case response.
- Sits between a local engine (DMA/mailbox sequencer) and the AXI4 interconnect as the sole master on its port.

---
 rtl/axi_burst_master.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - AXI4 INCR burst master, one command at a time
// Optional watchdog: define AXI_BURST_MASTER_TIMEOUT_EN to enable TIMEOUT_CYCLES.
module axi_burst_master #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          MAX_BURST  = 16,
    parameter logic [3:0]  ID_VALUE   = 4'd0
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    , parameter int        TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              resp,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [3:0]              awid,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [3:0]              arid,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);
    localparam int         STRB_W = DATA_WIDTH / 8;
    localparam logic [2:0] SIZE   = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {IDLE, CHK, AW, W, B, AR, R, DONE} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [7:0]              cnt_q;
    logic                    write_q;
    logic [1:0]              resp_q;
    logic                    cmd_ready_q, awvalid_q, arvalid_q, bready_q, done_q, error_q;

    // End offset of the burst within its 4 KB page; 14 bits covers 4095 + 256*16.
    logic [13:0] end_off;
    logic        reject;
    logic [1:0]  r_merged;
    logic        w_hs, r_hs, last_beat;

    assign end_off   = {2'b00, addr_q[11:0]} + ({6'b0, len_q} + 14'd1) * 14'(STRB_W);
    assign reject    = (end_off > 14'd4096) || (({1'b0, len_q} + 9'd1) > 9'(MAX_BURST));
    assign r_merged  = (rresp > resp_q) ? rresp : resp_q;
    assign last_beat = (cnt_q == len_q);
    assign w_hs      = wvalid && wready;
    assign r_hs      = rvalid && rready;

    assign cmd_ready = cmd_ready_q;
    assign awvalid   = awvalid_q;
    assign arvalid   = arvalid_q;
    assign bready    = bready_q;
    assign done      = done_q;
    assign error     = error_q;
    assign resp      = resp_q;
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign awlen     = len_q;
    assign arlen     = len_q;
    assign awsize    = SIZE;
    assign arsize    = SIZE;
    assign awburst   = 2'b01;
    assign arburst   = 2'b01;
    assign awid      = ID_VALUE;
    assign arid      = ID_VALUE;

    // Data channels are zero-latency pass-throughs gated by the state.
    assign wvalid    = (state_q == W) && wr_valid;
    assign wr_ready  = (state_q == W) && wready;
    assign wdata     = wr_data;
    assign wstrb     = wr_strb;
    assign wlast     = (state_q == W) && last_beat;
    assign rd_valid  = (state_q == R) && rvalid;
    assign rready    = (state_q == R) && rd_ready;
    assign rd_data   = rdata;
    assign rd_last   = (state_q == R) && rlast;

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_q;
    logic            timed, any_hs, to_expire;
    assign timed     = (state_q == AW) || (state_q == W) || (state_q == B) ||
                       (state_q == AR) || (state_q == R);
    assign any_hs    = (awvalid_q && awready) || w_hs || (bvalid && bready_q) ||
                       (arvalid_q && arready) || r_hs;
    assign to_expire = timed && !any_hs && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            resp_q      <= 2'b00;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
            to_q        <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        addr_q      <= cmd_addr;
                        len_q       <= cmd_len;
                        write_q     <= cmd_write;
                        cmd_ready_q <= 1'b0;
                        state_q     <= CHK;
                    end
                end
                CHK: begin
                    cnt_q <= '0;
                    if (reject) begin
                        resp_q  <= 2'b10;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        resp_q    <= 2'b00;
                        awvalid_q <= write_q;
                        arvalid_q <= !write_q;
                        state_q   <= write_q ? AW : AR;
                    end
                end
                AW: if (awready) begin
                    awvalid_q <= 1'b0;
                    state_q   <= W;
                end
                W: if (w_hs) begin
                    cnt_q <= cnt_q + 8'd1;
                    if (last_beat) begin
                        bready_q <= 1'b1;
                        state_q  <= B;
                    end
                end
                B: if (bvalid) begin
                    bready_q <= 1'b0;
                    resp_q   <= bresp;
                    done_q   <= 1'b1;
                    error_q  <= (bresp != 2'b00);
                    state_q  <= DONE;
                end
                AR: if (arready) begin
                    arvalid_q <= 1'b0;
                    state_q   <= R;
                end
                R: if (r_hs) begin
                    cnt_q <= cnt_q + 8'd1;
                    if (rlast || last_beat) begin
                        // RLAST early or missing is a protocol error.
                        resp_q  <= (rlast && last_beat) ? r_merged : 2'b10;
                        error_q <= (rlast && last_beat) ? (r_merged != 2'b00) : 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        resp_q <= r_merged;
                    end
                end
                DONE: begin
                    done_q      <= 1'b0;
                    error_q     <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
            if (to_expire) begin
                awvalid_q <= 1'b0;
                arvalid_q <= 1'b0;
                bready_q  <= 1'b0;
                resp_q    <= 2'b11;
                done_q    <= 1'b1;
                error_q   <= 1'b1;
                state_q   <= DONE;
                to_q      <= '0;
            end else if (!timed || any_hs) begin
                to_q <= '0;
            end else begin
                to_q <= to_q + 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - self-checking bench for axi_burst_master
module tb_axi_burst_master;
    localparam int TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done, error;
    logic [1:0]  resp;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  awid, arid, wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi_burst_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(16), .ID_VALUE(4'd0)
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO_CYC)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .error(error), .resp(resp),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0]  rr   [0:255];
    logic [31:0] wdat [0:255];
    logic [3:0]  wstb [0:255];
    logic [31:0] rdat [0:255];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit chance(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    function automatic bit model_reject(input logic [31:0] a, input int len);
        return ((a % 4096) + (len + 1) * 4 > 4096) || (len + 1 > 16);
    endfunction

    function automatic logic [1:0] model_resp(input bit wr, input logic [31:0] a, input int len,
                                              input logic [1:0] br, input int rl);
        logic [1:0] m = 2'b00;
        if (model_reject(a, len)) return 2'b10;
        if (wr) return br;
        if (rl != len) return 2'b10;
        for (int i = 0; i <= len; i++) if (rr[i] > m) m = rr[i];
        return m;
    endfunction

    task automatic clear_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0; arready = 0;
        rvalid = 0; rdata = '0; rresp = '0; rlast = 0;
    endtask

    task automatic run(input string nm, input bit wr, input logic [31:0] addr, input int len,
                       input logic [1:0] br, input int rl, input int pct, input bit aw_block,
                       input int abort_wbeat, input logic [1:0] exp_resp);
        int  wbeat = 0, rbeat = 0, aw_cnt = 0, ar_cnt = 0, awv_cyc = 0;
        bit  cmd_pend = 1, aw_done = 0, ar_done = 0, b_done = 0, done_seen = 0;
        bit  wv_hold = 0, rv_hold = 0, bv_hold = 0, rej;
        rej = model_reject(addr, len);
        for (int i = 0; i < 256; i++) begin
            wdat[i] = $urandom; wstb[i] = 4'($urandom); rdat[i] = $urandom;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            cmd_valid = cmd_pend; cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len);
            awready   = aw_block ? 1'b0 : chance(pct);
            arready   = chance(pct);
            wr_valid  = wr && (wbeat <= len) && (wv_hold || chance(pct));
            wr_data   = wdat[wbeat & 255]; wr_strb = wstb[wbeat & 255];
            wready    = chance(pct);
            bvalid    = bv_hold || (aw_done && wbeat > len && !b_done && chance(pct));
            bresp     = br;
            rvalid    = rv_hold || (ar_done && rbeat <= rl && chance(pct));
            rdata     = rdat[rbeat & 255]; rresp = rr[rbeat & 255]; rlast = (rbeat == rl);
            rd_ready  = chance(pct);
            #1;
            if (done_seen) begin
                check({nm, " done_single"}, done, 0);
                check({nm, " idle_ready"}, cmd_ready, 1);
                clear_inputs();
                return;
            end
            if (cmd_valid && cmd_ready) cmd_pend = 0;
            if (awvalid) begin
                awv_cyc++;
                if (awready) begin
                    aw_cnt++; aw_done = 1;
                    check({nm, " aw_fields"}, {awaddr, awlen, awsize, awburst, awid},
                          {addr, 8'(len), 3'd2, 2'b01, 4'd0});
                end
            end
            if (arvalid && arready) begin
                ar_cnt++; ar_done = 1;
                check({nm, " ar_fields"}, {araddr, arlen, arsize, arburst, arid},
                      {addr, 8'(len), 3'd2, 2'b01, 4'd0});
            end
            wv_hold = wr_valid && !wr_ready;
            if (wvalid && wready) begin
                check({nm, " w_beat"}, {wdata, wstrb, wlast, wr_ready},
                      {wdat[wbeat & 255], wstb[wbeat & 255], wbeat == len, 1'b1});
                wbeat++;
            end
            bv_hold = bvalid && !bready;
            if (bvalid && bready) b_done = 1;
            rv_hold = rvalid && !rready;
            if (rvalid && rready) begin
                check({nm, " r_beat"}, {rd_data, rd_last, rd_valid},
                      {rdat[rbeat & 255], rbeat == rl, 1'b1});
                rbeat++;
            end
            if (abort_wbeat >= 0 && wbeat == abort_wbeat) begin
                rst_n = 0;
                #1;
                check({nm, " reset_valids"},
                      {awvalid, wvalid, arvalid, bready, rready, rd_valid, cmd_ready, done},
                      8'h00);
                clear_inputs();
                @(negedge clk);
                rst_n = 1;
                return;
            end
            if (done) begin
                done_seen = 1;
                check({nm, " resp"}, {resp, error}, {exp_resp, exp_resp != 2'b00});
                check({nm, " aw_ar_count"}, {aw_cnt, ar_cnt},
                      {32'(!rej && wr && !aw_block), 32'(!rej && !wr)});
                if (wr) check({nm, " w_count"}, wbeat, (rej || aw_block) ? 0 : len + 1);
                else    check({nm, " r_count"}, rbeat, rej ? 0 : ((rl < len ? rl : len) + 1));
                if (aw_block) check({nm, " aw_timeout"}, awv_cyc, TO_CYC);
            end
        end
        check({nm, " no_done_within_budget"}, done_seen, 1);
        clear_inputs();
    endtask

    typedef struct {
        string       nm;
        bit          wr;
        logic [31:0] addr;
        int          len;
        logic [1:0]  br;
        logic [31:0] rr_pat;
        int          rl;
        int          pct;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{"wr_basic",     1, 32'h0000_1000,  3, 2'b00, 32'h0,        3,  100, 2'b00};
        vecs[1] = '{"rd_gaps",      0, 32'h0000_2000,  7, 2'b00, 32'h0,        7,  50,  2'b00};
        vecs[2] = '{"rd_merge",     0, 32'h0000_3000,  3, 2'b00, 32'h0000_00C8, 3, 60,  2'b11};
        vecs[3] = '{"wr_4k_cross",  1, 32'h0000_0FF8,  3, 2'b00, 32'h0,        3,  100, 2'b10};
        vecs[4] = '{"wr_4k_edge",   1, 32'h0000_0FF0,  3, 2'b01, 32'h0,        3,  70,  2'b01};
        vecs[5] = '{"rd_too_long",  0, 32'h0000_4000, 16, 2'b00, 32'h0,       16,  100, 2'b10};
        vecs[6] = '{"rd_early_last",0, 32'h0000_5000,  3, 2'b00, 32'h0,        1,  100, 2'b10};
        vecs[7] = '{"rd_no_last",   0, 32'h0000_6000,  2, 2'b00, 32'h0,        5,  80,  2'b10};
        vecs[8] = '{"wr_single",    1, 32'h0000_7004,  0, 2'b10, 32'h0,        0,  100, 2'b10};
        vecs[9] = '{"rd_max_edge",  0, 32'h0000_1FC0, 15, 2'b00, 32'h5555_5555, 15, 50, 2'b01};

        clear_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state",
              {cmd_ready, awvalid, wvalid, arvalid, bready, rready, wr_ready, rd_valid,
               rd_last, done, error, resp}, 13'h0);
        @(negedge clk);
        rst_n = 1;

        foreach (vecs[k]) begin
            for (int i = 0; i < 256; i++) rr[i] = 2'b00;
            for (int i = 0; i < 16; i++) rr[i] = vecs[k].rr_pat[2*i +: 2];
            run(vecs[k].nm, vecs[k].wr, vecs[k].addr, vecs[k].len, vecs[k].br, vecs[k].rl,
                vecs[k].pct, 0, -1, vecs[k].exp_resp);
        end

        run("wr_reset_mid", 1, 32'h0000_8000, 3, 2'b00, 3, 100, 0, 1, 2'b00);
        run("wr_after_reset", 1, 32'h0000_8000, 3, 2'b00, 3, 100, 0, -1, 2'b00);

        for (int t = 0; t < 24; t++) begin
            bit          wr;
            logic [31:0] a;
            int          len, rl;
            logic [1:0]  br;
            wr  = 1'($urandom);
            a   = $urandom;
            a   = {a[31:12], 12'($urandom_range(0, 1023) * 4)};
            len = $urandom_range(0, 18);
            rl  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 2) : len;
            br  = 2'($urandom);
            for (int i = 0; i < 256; i++) rr[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            run($sformatf("rand%0d", t), wr, a, len, br, rl, $urandom_range(30, 100), 0, -1,
                model_resp(wr, a, len, br, rl));
        end

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
        run("aw_timeout", 1, 32'h0000_9000, 3, 2'b00, 3, 100, 1, -1, 2'b11);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
